// File: rtl/picoMIPS_pkg.sv
// Shared types for the picoMIPS fetch path: PC width, PC type, fetch FSM states
// and the next-PC source select.
package picoMIPS_pkg;
  localparam int Psize = 6;

  typedef logic [Psize-1:0] pc_t;

  typedef enum logic [1:0] {RUN, WAIT, HALT} fetch_state_t;

  typedef enum logic [1:0] {SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP} pc_sel_t;
endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: hold, increment, PC-relative branch or absolute jump.
// All arithmetic wraps silently at Psize bits.
module pc_next
  import picoMIPS_pkg::*;
(
  input  pc_t     pc_i,
  input  pc_t     offset_i,
  input  pc_t     target_i,
  input  pc_sel_t sel_i,
  output pc_t     pc_o
);

  // A plain Psize-bit add gives the sign-extended displacement result modulo 2^Psize.
  always_comb begin
    pc_o = pc_i;
    case (sel_i)
      SEL_INC:  pc_o = pc_i + pc_t'(1);
      SEL_BR:   pc_o = pc_i + offset_i;
      SEL_JMP:  pc_o = target_i;
      default:  pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// picoMIPS program counter and fetch sequencer (RUN / WAIT / HALT), one-cycle control latency.
// Drives the program memory address directly from the PC register; en low freezes everything.
module pc_fetch
  import picoMIPS_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             branch,
  input  logic             jump,
  input  logic [Psize-1:0] offset,
  input  logic [Psize-1:0] target,
  input  logic             wait_req,
  input  logic             wait_ack,
  input  logic             halt_req,
  output logic [Psize-1:0] address,
  output logic             waiting,
  output logic             halted
);

  fetch_state_t state_q, state_d;
  pc_t          pc_q, pc_d;
  pc_sel_t      sel;
  logic         waiting_q, halted_q;

  always_comb begin
    sel     = SEL_HOLD;
    state_d = state_q;
    if (en) begin
      case (state_q)
        RUN: begin
          if (halt_req)                  state_d = HALT;
          else if (jump)                 sel     = SEL_JMP;
          else if (branch)               sel     = SEL_BR;
          else if (wait_req && !wait_ack) state_d = WAIT;
          else                           sel     = SEL_INC;
        end
        WAIT: begin
          // branch/jump are deliberately not looked at while waiting for operand
          if (halt_req) begin
            state_d = HALT;
          end else if (wait_ack) begin
            sel     = SEL_INC;
            state_d = RUN;
          end
        end
        default: begin
          sel     = SEL_HOLD;
          state_d = state_q;
        end
      endcase
    end
  end

  pc_next u_pc_next (
    .pc_i     (pc_q),
    .offset_i (offset),
    .target_i (target),
    .sel_i    (sel),
    .pc_o     (pc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      waiting_q <= (state_d == WAIT);
      halted_q  <= (state_d == HALT);
    end
  end

  assign address = pc_q;
  assign waiting = waiting_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against an integer-arithmetic reference model.
module tb_pc_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       branch = 1'b0;
  logic       jump = 1'b0;
  logic [5:0] offset = '0;
  logic [5:0] target = '0;
  logic       wait_req = 1'b0;
  logic       wait_ack = 1'b0;
  logic       halt_req = 1'b0;
  logic [5:0] address;
  logic       waiting;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // reference model: m_st 0=running, 1=waiting for operand, 2=halted
  int m_pc = 0;
  int m_st = 0;

  pc_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .branch   (branch),
    .jump     (jump),
    .offset   (offset),
    .target   (target),
    .wait_req (wait_req),
    .wait_ack (wait_ack),
    .halt_req (halt_req),
    .address  (address),
    .waiting  (waiting),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    int off;
    if (reset) begin
      m_pc = 0;
      m_st = 0;
    end else if (en) begin
      off = offset[5] ? int'(offset) - 64 : int'(offset);
      if (m_st == 0) begin
        if (halt_req)                   m_st = 2;
        else if (jump)                  m_pc = int'(target);
        else if (branch)                m_pc = ((m_pc + off) % 64 + 64) % 64;
        else if (wait_req && !wait_ack) m_st = 1;
        else                            m_pc = (m_pc + 1) % 64;
      end else if (m_st == 1) begin
        if (halt_req) m_st = 2;
        else if (wait_ack) begin
          m_pc = (m_pc + 1) % 64;
          m_st = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_address", int'(address), m_pc);
      chk("model_waiting", int'(waiting), int'(m_st == 1));
      chk("model_halted",  int'(halted),  int'(m_st == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ctl();
    branch = 0; jump = 0; wait_req = 0; wait_ack = 0; halt_req = 0;
    offset = '0; target = '0;
  endtask

  task automatic goto_pc(input int pc);
    jump = 1; target = 6'(pc);
    tick();
    jump = 0;
  endtask

  // reset asserted between edges must clear outputs before any clock edge
  task automatic mid_reset(input string name);
    #1 reset = 1;
    #1;
    chk({name, "_addr"},    int'(address), 0);
    chk({name, "_waiting"}, int'(waiting), 0);
    chk({name, "_halted"},  int'(halted),  0);
    clear_ctl();
    tick();
    reset = 0;
  endtask

  initial begin
    #1 reset = 1;
    #2;
    chk("reset_addr",    int'(address), 0);
    chk("reset_waiting", int'(waiting), 0);
    chk("reset_halted",  int'(halted),  0);
    tick();
    reset = 0;
    en = 1;
    chk_on = 1;

    for (int i = 0; i < 70; i++) begin
      tick();
      chk("seq_inc", int'(address), (i + 1) % 64);
    end

    goto_pc(10); branch = 1; offset = 6'b111101; tick(); branch = 0;
    chk("branch_10_m3", int'(address), 7);
    goto_pc(62); branch = 1; offset = 6'd5; tick(); branch = 0;
    chk("branch_62_p5", int'(address), 3);
    goto_pc(2); branch = 1; offset = 6'b111101; tick(); branch = 0;
    chk("branch_2_m3", int'(address), 63);
    goto_pc(5); branch = 1; jump = 1; target = 6'd20; offset = 6'd3; tick(); clear_ctl();
    chk("jump_over_branch", int'(address), 20);

    goto_pc(4); wait_req = 1; tick();
    chk("wait_enter", int'(waiting), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_hold_addr", int'(address), 4);
    end
    jump = 1; target = 6'd50; branch = 1; tick(); jump = 0; branch = 0;
    chk("wait_ignores_jump", int'(address), 4);
    en = 0; wait_ack = 1; tick(); en = 1;
    chk("wait_en_low", int'(waiting), 1);
    wait_req = 0; tick();
    chk("wait_ack_addr", int'(address), 5);
    chk("wait_ack_run", int'(waiting), 0);
    tick(); wait_ack = 0;
    chk("ack_once", int'(address), 6);

    goto_pc(8); wait_req = 1; wait_ack = 1; tick(); clear_ctl();
    chk("wait_satisfied", int'(address), 9);
    chk("wait_satisfied_w", int'(waiting), 0);

    goto_pc(12); halt_req = 1; tick(); halt_req = 0;
    chk("halt_addr", int'(address), 12);
    chk("halt_flag", int'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      jump = i[0]; branch = ~i[0]; wait_ack = i[1]; target = 6'd33; offset = 6'd7;
      tick();
      chk("halt_sticky", int'(address), 12);
    end
    mid_reset("halt_reset");
    tick();
    chk("after_halt_reset", int'(address), 1);

    goto_pc(9); en = 0; jump = 1; target = 6'd40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_low_hold", int'(address), 9);
    end
    en = 1; jump = 0; tick();
    chk("en_resume", int'(address), 10);

    goto_pc(30); wait_req = 1; tick();
    chk("wait_at_30", int'(waiting), 1);
    mid_reset("wait_reset");
    tick();
    chk("after_wait_reset", int'(address), 1);

    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      branch   = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 5) == 0);
      wait_req = ($urandom_range(0, 3) == 0);
      wait_ack = ($urandom_range(0, 2) == 0);
      halt_req = ($urandom_range(0, 40) == 0);
      offset   = 6'($urandom);
      target   = 6'($urandom);
      if (m_st == 2 && $urandom_range(0, 5) == 0) begin
        #1 reset = 1;
        #1 reset = 0;
      end
      tick();
    end

    @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
